// File: rtl/ram_fill_check.sv
// Self-checking RAM exerciser: fills a dual-port RAM with an address-derived pattern, reads it back, counts bad words.
// Optional first-failing-address capture is built when RAM_FILL_CHECK_FIRST_ERR_EN is defined.
module ram_fill_check #(
  parameter int RAM_ADDR_W = 8,
  parameter int CHUNK_W    = 32,
  parameter int CHUNK_CNT  = 4,
  parameter int SEED       = 0,
  parameter int RD_LAT     = 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o,
  output logic [RAM_ADDR_W-1:0]         first_err_addr_o,
  output logic [RAM_ADDR_W-1:0]         ram_wr_addr_o,
  output logic [CHUNK_CNT*CHUNK_W-1:0]  ram_wr_data_o,
  output logic                          ram_wr_en_o,
  output logic [RAM_ADDR_W-1:0]         ram_rd_addr_o,
  output logic                          ram_rd_en_o,
  input  logic [CHUNK_CNT*CHUNK_W-1:0]  ram_rd_data_i
);

  localparam int DATA_W = CHUNK_CNT * CHUNK_W;
  localparam logic [RAM_ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic [ERR_CNT_W-1:0]    r_err_cnt;
  logic [RAM_ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]       r_wr_data;
  logic                    r_wr_en;
  logic [RAM_ADDR_W-1:0]   r_rd_addr;
  logic                    r_rd_en;
  logic [1:0]              r_drain_cnt;
  logic                    r_pv [RD_LAT];
  logic [RAM_ADDR_W-1:0]   r_pa [RD_LAT];

  logic                    w_start;
  logic                    w_mismatch;
  logic [ERR_CNT_W-1:0]    w_err_next;

  function automatic logic [DATA_W-1:0] pattern(input logic [RAM_ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = '0;
    for (int g = 0; g < CHUNK_CNT; g++)
      word[g*CHUNK_W +: CHUNK_W] = CHUNK_W'(addr) + CHUNK_W'(g) + CHUNK_W'(SEED);
    return word;
  endfunction

  assign w_start = (r_state == S_IDLE) && start_i;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    w_mismatch = r_pv[RD_LAT-1] && (ram_rd_data_i != pattern(r_pa[RD_LAT-1]));
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != '1))
      w_err_next = r_err_cnt + ERR_CNT_W'(1);
  end

  // Valid/address pipe lines each returning word up with the address it was read from.
  // NOTE: the pipe is reset so a run abandoned by reset cannot leak a compare into the next one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_rd_en;
      r_pa[0] <= r_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments; later assignments in the block win.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err_cnt <= w_err_next;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_state   <= S_FILL;
          r_busy    <= 1'b1;
          r_wr_en   <= 1'b1;
          r_wr_addr <= '0;
          r_wr_data <= pattern('0);
          r_err_cnt <= '0;
          r_pass    <= 1'b0;
        end
        S_FILL: if (r_wr_addr == LAST_ADDR) begin
          r_state   <= S_CHECK;
          r_wr_en   <= 1'b0;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
        end else begin
          r_wr_addr <= r_wr_addr + 1'b1;
          r_wr_data <= pattern(r_wr_addr + 1'b1);
        end
        S_CHECK: if (r_rd_addr == LAST_ADDR) begin
          r_state     <= S_DRAIN;
          r_rd_en     <= 1'b0;
          r_drain_cnt <= 2'(RD_LAT - 1);
        end else begin
          r_rd_addr <= r_rd_addr + 1'b1;
        end
        // The last compare lands in the final DRAIN cycle, so pass uses the next count.
        S_DRAIN: if (r_drain_cnt == '0) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == '0);
        end else begin
          r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RAM_FILL_CHECK_FIRST_ERR_EN
  logic [RAM_ADDR_W-1:0] r_first_err_addr;

  // An error count of zero means no mismatch has been captured yet in this run.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_first_err_addr <= '0;
    else if (w_start)
      r_first_err_addr <= '0;
    else if (w_mismatch && (r_err_cnt == '0))
      r_first_err_addr <= r_pa[RD_LAT-1];
  end

  assign first_err_addr_o = r_first_err_addr;
`else
  assign first_err_addr_o = '0;
`endif

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign err_cnt_o     = r_err_cnt;
  assign ram_wr_addr_o = r_wr_addr;
  assign ram_wr_data_o = r_wr_data;
  assign ram_wr_en_o   = r_wr_en;
  assign ram_rd_addr_o = r_rd_addr;
  assign ram_rd_en_o   = r_rd_en;

endmodule

// File: tb/tb_ram_fill_check.sv
// Bench for ram_fill_check: two instances (defaults; RD_LAT=2, 4-bit counter, negative seed) against behavioural RAMs
// with injectable read faults, checked against a reference computed from the pattern rule.
module tb_ram_fill_check;

  localparam int AW      = 8;
  localparam int DW      = 128;
  localparam int DEPTH   = 1 << AW;
  localparam int B_ERR_W = 4;
  localparam int B_SEED  = -2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_start = 1'b0, a_busy, a_done, a_pass, a_wr_en, a_rd_en;
  logic [15:0] a_err;
  logic [AW-1:0] a_first, a_wr_addr, a_rd_addr;
  logic [DW-1:0] a_wr_data, a_rd_data;

  logic b_start = 1'b0, b_busy, b_done, b_pass, b_wr_en, b_rd_en;
  logic [B_ERR_W-1:0] b_err;
  logic [AW-1:0] b_first, b_wr_addr, b_rd_addr;
  logic [DW-1:0] b_wr_data, b_rd_data, b_rd_q;

  ram_fill_check u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .pass_o(a_pass), .err_cnt_o(a_err), .first_err_addr_o(a_first),
    .ram_wr_addr_o(a_wr_addr), .ram_wr_data_o(a_wr_data), .ram_wr_en_o(a_wr_en),
    .ram_rd_addr_o(a_rd_addr), .ram_rd_en_o(a_rd_en), .ram_rd_data_i(a_rd_data)
  );

  ram_fill_check #(.RD_LAT(2), .ERR_CNT_W(B_ERR_W), .SEED(B_SEED)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .pass_o(b_pass), .err_cnt_o(b_err), .first_err_addr_o(b_first),
    .ram_wr_addr_o(b_wr_addr), .ram_wr_data_o(b_wr_data), .ram_wr_en_o(b_wr_en),
    .ram_rd_addr_o(b_rd_addr), .ram_rd_en_o(b_rd_en), .ram_rd_data_i(b_rd_data)
  );

  // Behavioural RAMs with a per-address XOR fault mask or a stuck-at-zero read port
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] fmask [DEPTH];
  bit            stuck = 1'b0;

  function automatic logic [DW-1:0] ram_read(input logic [DW-1:0] w, input logic [AW-1:0] addr);
    return stuck ? '0 : (w ^ fmask[addr]);
  endfunction

  always @(posedge clk) begin
    if (a_wr_en) mem_a[a_wr_addr] <= a_wr_data;
    if (a_rd_en) a_rd_data <= ram_read(mem_a[a_rd_addr], a_rd_addr);
    if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
    if (b_rd_en) b_rd_q <= ram_read(mem_b[b_rd_addr], b_rd_addr);
    b_rd_data <= b_rd_q;
  end

  // Observation mux onto whichever instance the current test drives
  bit sel = 1'b0;
  logic o_busy, o_done, o_pass, o_wr_en, o_rd_en;
  logic [15:0] o_err;
  logic [AW-1:0] o_first, o_wr_addr;
  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_done = b_done; o_pass = b_pass; o_wr_en = b_wr_en; o_rd_en = b_rd_en;
      o_err = {{(16-B_ERR_W){1'b0}}, b_err}; o_first = b_first; o_wr_addr = b_wr_addr;
    end else begin
      o_busy = a_busy; o_done = a_done; o_pass = a_pass; o_wr_en = a_wr_en; o_rd_en = a_rd_en;
      o_err = a_err; o_first = a_first; o_wr_addr = a_wr_addr;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference pattern: chunk g of address A is (A + g + seed) mod 2^32
  function automatic logic [DW-1:0] model_word(input int addr, input int seed);
    logic [DW-1:0] w;
    for (int g = 0; g < 4; g++) w[g*32 +: 32] = 32'(addr + g + seed);
    return w;
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) fmask[a] = '0;
    stuck = 1'b0;
  endtask

  task automatic run_test(input bit s, input bit hold, input string tag);
    int seed, errw, lat, bad, first, exp_err, exp_first;
    int cyc, done_cyc, wr_n, rd_n, first_rd, bad_words;
    logic [DW-1:0] w, rd;
    seed = s ? B_SEED : 0;
    errw = s ? B_ERR_W : 16;
    lat  = s ? 2 : 1;
    bad = 0; first = -1;
    for (int a = 0; a < DEPTH; a++) begin
      w  = model_word(a, seed);
      rd = stuck ? '0 : (w ^ fmask[a]);
      if (rd != w) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    exp_err = (bad > (1 << errw) - 1) ? (1 << errw) - 1 : bad;
`ifdef RAM_FILL_CHECK_FIRST_ERR_EN
    exp_first = (first < 0) ? 0 : first;
`else
    exp_first = 0;
`endif

    sel = s;
    @(negedge clk);
    if (s) b_start = 1'b1; else a_start = 1'b1;
    cyc = 0; done_cyc = 0; wr_n = 0; rd_n = 0; first_rd = 0;
    while (done_cyc == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "/c1_busy_wr_rd"}, {o_busy, o_wr_en, o_rd_en}, 3'b110);
        check({tag, "/c1_wr_addr"}, o_wr_addr, 0);
        check({tag, "/c1_cleared"}, {o_pass, o_err, o_first}, 0);
        if (!hold) begin a_start = 1'b0; b_start = 1'b0; end
      end
      if (o_wr_en) wr_n++;
      if (o_rd_en) begin
        rd_n++;
        if (first_rd == 0) first_rd = cyc;
      end
      if (o_done) done_cyc = cyc;
    end
    a_start = 1'b0; b_start = 1'b0;
    check({tag, "/done_cycle"}, done_cyc, 2 * DEPTH + lat + 1);
    check({tag, "/wr_cycles"}, wr_n, DEPTH);
    check({tag, "/rd_cycles"}, rd_n, DEPTH);
    check({tag, "/first_rd_cycle"}, first_rd, DEPTH + 1);
    @(negedge clk);
    check({tag, "/idle_after_done"}, {o_done, o_busy}, 2'b00);
    check({tag, "/pass"}, o_pass, (bad == 0));
    check({tag, "/err_cnt"}, o_err, exp_err);
    check({tag, "/first_err"}, o_first, exp_first);
    bad_words = 0;
    for (int a = 0; a < DEPTH; a++)
      if ((s ? mem_b[a] : mem_a[a]) !== model_word(a, seed)) bad_words++;
    check({tag, "/ram_contents"}, bad_words, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/a_outputs"}, {a_busy, a_done, a_pass, a_err, a_first, a_wr_en, a_wr_addr, a_rd_en, a_rd_addr}, 0);
    check({tag, "/a_wr_data"}, a_wr_data, 0);
    check({tag, "/b_outputs"}, {b_busy, b_done, b_pass, b_err, b_first, b_wr_en, b_wr_addr, b_rd_en, b_rd_addr}, 0);
  endtask

  task automatic reset_mid_run();
    int done_n;
    sel = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) a_start = 1'b0;
    end
    check("mid_fill/wr_addr", {a_wr_en, a_wr_addr}, {1'b1, 8'd99});
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_fill_reset");
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_done) done_n++;
    end
    check("mid_fill/no_done", done_n, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int nf, addr;
    clear_faults();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_test(1'b0, 1'b0, "ideal");

    clear_faults();
    fmask[8'h37][64] = 1'b1;
    run_test(1'b0, 1'b0, "flip_37");

    clear_faults();
    stuck = 1'b1;
    run_test(1'b0, 1'b0, "stuck_a");
    run_test(1'b1, 1'b0, "stuck_b_sat");

    clear_faults();
    fmask[8'h80][3] = 1'b1;
    run_test(1'b0, 1'b1, "held_start");
    clear_faults();
    run_test(1'b0, 1'b0, "back_to_back");

    reset_mid_run();
    run_test(1'b0, 1'b0, "after_reset");

    run_test(1'b1, 1'b0, "lat2_ideal");

    for (int it = 0; it < 6; it++) begin
      clear_faults();
      nf = $urandom_range(0, 20);
      for (int k = 0; k < nf; k++) begin
        addr = $urandom_range(0, DEPTH - 1);
        fmask[addr][$urandom_range(0, DW - 1)] = 1'b1;
      end
      stuck = ($urandom_range(0, 7) == 0);
      run_test(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_fill_check.md
# ram_fill_check

Self-checking RAM exerciser that sits directly upstream of the `mem` dual-port RAM in the stress design. It owns both RAM ports for one test run:
- fills every address with a deterministic pattern;
- reads the whole array back and compares each word with the expected value;
- reports pass/fail, the error count and, optionally, the first failing address.

## Interface
Parameters:
- `RAM_ADDR_W`, 8, RAM address width; the array depth is 2^`RAM_ADDR_W` words.
- `CHUNK_W`, 32, width of one data chunk.
- `CHUNK_CNT`, 4, number of chunks per RAM word; the word width is `CHUNK_CNT*CHUNK_W`.
- `SEED`, 0, constant added into the pattern.
- `RD_LAT`, 1, RAM read latency in cycles; legal values are 1 and 2.
- `ERR_CNT_W`, 16, width of the error counter.

Ports:
- `clk_i`, in, 1, clock.
- `rst_n_i`, in, 1, asynchronous active-low reset.
- `start_i`, in, 1, start request; one cycle is enough.
- `busy_o`, out, 1, high while the FSM is not in IDLE.
- `done_o`, out, 1, one-cycle pulse when a run finishes.
- `pass_o`, out, 1, result of the last run: 1 means no errors.
- `err_cnt_o`, out, `ERR_CNT_W`, number of mismatching words; saturates.
- `first_err_addr_o`, out, `RAM_ADDR_W`, address of the first mismatch (only with the macro).
- `ram_wr_addr_o`, out, `RAM_ADDR_W`, write address.
- `ram_wr_data_o`, out, `CHUNK_CNT*CHUNK_W`, write data.
- `ram_wr_en_o`, out, 1, write enable.
- `ram_rd_addr_o`, out, `RAM_ADDR_W`, read address.
- `ram_rd_en_o`, out, 1, read enable.
- `ram_rd_data_i`, in, `CHUNK_CNT*CHUNK_W`, read data; valid `RD_LAT` cycles after the read is issued.

## Operation
- Pattern for address A:
  - chunk g = (zero-extended A + g + `SEED`) mod 2^`CHUNK_W`;
  - chunk 0 occupies the LSBs.
- FSM states: IDLE, FILL, CHECK, DRAIN, DONE.
- IDLE:
  - all enables are low;
  - `start_i` moves the FSM to FILL and clears `err_cnt_o`, `pass_o` and `first_err_addr_o`.
- FILL:
  - `ram_wr_en_o` is 1;
  - the address counts from 0 up to 2^N−1, one address per cycle;
  - after the last address is written, go to CHECK.
- CHECK:
  - `ram_rd_en_o` is 1;
  - the read address counts from 0 up to 2^N−1;
  - each issued address is pushed into an `RD_LAT`-deep valid/address pipe;
  - after the last read is issued, go to DRAIN.
- DRAIN: stay for `RD_LAT` cycles so every issued read is compared, then go to DONE.
- DONE:
  - `done_o` is 1 for this one cycle;
  - `pass_o` is set to (error count == 0);
  - next state is IDLE.
- Compare:
  - at the pipe output, the whole word is compared with the pattern for the piped address;
  - any chunk differing counts as exactly 1 error for that word;
  - `err_cnt_o` saturates at all-ones.
- `start_i` is ignored while `busy_o` is high.
- Results hold until the next accepted start.
- Address counters are exactly `RAM_ADDR_W` bits wide. The end of a phase is detected by address == all-ones, not by overflow.

## Timing
- The cycle in which `start_i` is sampled is cycle 0. With N = `RAM_ADDR_W`:
  - FILL occupies cycles 1 to 2^N;
  - CHECK occupies cycles 2^N+1 to 2^(N+1);
  - DRAIN occupies the next `RD_LAT` cycles;
  - `done_o` rises in cycle 2^(N+1)+`RD_LAT`+1.
- Write and read phases never overlap, so there is no read-during-write hazard.
- All RAM-facing outputs are registered.
- Reset values:
  - every output is 0;
  - the FSM is in IDLE.
- Reset asserted mid-run:
  - enables drop immediately (asynchronous reset);
  - the run is abandoned;
  - no `done_o` pulse is produced.
- `start_i` in the same cycle as the DONE pulse is ignored; the FSM accepts a start only in IDLE.

## Configuration
- `RAM_FILL_CHECK_FIRST_ERR_EN`.
- When defined:
  - `first_err_addr_o` captures the address of the first mismatch of a run;
  - later mismatches do not overwrite it.
- When undefined:
  - the capture logic is not built;
  - `first_err_addr_o` is tied to 0.

## Test plan
- Ideal RAM model, defaults, start pulse:
  - `done_o` in cycle 514;
  - `pass_o` = 1;
  - `err_cnt_o` = 0.
- Model flips bit 0 of chunk 2 at address 0x37:
  - `err_cnt_o` = 1;
  - `pass_o` = 0;
  - `first_err_addr_o` = 0x37 with the macro defined, 0 without it.
- Model returns data stuck at 0:
  - `err_cnt_o` = 256;
  - `first_err_addr_o` = 0x00.
  - Repeat with `ERR_CNT_W` = 4: `err_cnt_o` = 15 (saturated).
- Start held high throughout the run, and a second run started immediately after DONE:
  - the held start produces exactly one run;
  - the second run clears the counters;
  - the clean result returns `pass_o` = 1.
- Reset asserted in cycle 100 (mid-FILL):
  - all outputs are 0 in the same cycle;
  - no `done_o` pulse;
  - a later start completes normally.
- `RD_LAT` = 2 with a 2-cycle RAM model:
  - `done_o` in cycle 515;
  - `pass_o` = 1.
